// File: rtl/data_mem_ctrl_pkg.sv
// rtl/data_mem_ctrl_pkg.sv - funct3 size codes, FSM state codes and access legality check
package data_mem_ctrl_pkg;

  localparam logic [2:0] SZ_B  = 3'b000;
  localparam logic [2:0] SZ_H  = 3'b001;
  localparam logic [2:0] SZ_W  = 3'b010;
  localparam logic [2:0] SZ_BU = 3'b100;
  localparam logic [2:0] SZ_HU = 3'b101;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_WRITE = 3'd1;
  localparam logic [2:0] ST_READ  = 3'd2;
  localparam logic [2:0] ST_MERGE = 3'd3;
  localparam logic [2:0] ST_LDONE = 3'd4;
  localparam logic [2:0] ST_RESP  = 3'd5;

  // Size/alignment legality only; the address-window check needs ADDR_W and lives in the top.
  function automatic logic size_align_err(input logic we, input logic [2:0] size,
                                          input logic [1:0] lo);
    logic err;
    case (size)
      SZ_B:    err = 1'b0;
      SZ_H:    err = lo[0];
      SZ_W:    err = (lo != 2'b00);
      SZ_BU:   err = we;
      SZ_HU:   err = we | lo[0];
      default: err = 1'b1;
    endcase
    return err;
  endfunction

endpackage

// File: rtl/data_mem_ctrl_align.sv
// rtl/data_mem_ctrl_align.sv - load lane extract/extend and store lane merge
module data_mem_ctrl_align
  import data_mem_ctrl_pkg::*;
(
  input  logic [2:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (addr_lo)
      2'd0:    byte_sel = word[7:0];
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      default: byte_sel = word[31:24];
    endcase
    half_sel = addr_lo[1] ? word[31:16] : word[15:0];

    load_data = '0;
    case (size)
      SZ_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
      SZ_BU:   load_data = {24'h0, byte_sel};
      SZ_H:    load_data = {{16{half_sel[15]}}, half_sel};
      SZ_HU:   load_data = {16'h0, half_sel};
      SZ_W:    load_data = word;
      default: load_data = '0;
    endcase

    // Only the addressed lane(s) take store data; the rest keep the word just read.
    merged = word;
    case (size)
      SZ_B: begin
        case (addr_lo)
          2'd0:    merged[7:0]   = wdata[7:0];
          2'd1:    merged[15:8]  = wdata[7:0];
          2'd2:    merged[23:16] = wdata[7:0];
          default: merged[31:24] = wdata[7:0];
        endcase
      end
      SZ_H: begin
        if (addr_lo[1]) merged[31:16] = wdata[15:0];
        else            merged[15:0]  = wdata[15:0];
      end
      default: merged = wdata;
    endcase
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// rtl/data_mem_ctrl.sv - RV32I data-memory controller over a single-port word RAM
module data_mem_ctrl
  import data_mem_ctrl_pkg::*;
#(
  parameter int          ADDR_W    = 9,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_size,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_din,
  output logic              ram_we,
  input  logic [31:0]       ram_dout
);

  logic [2:0]        state_q, state_d;
  logic              we_q;
  logic [2:0]        size_q;
  logic [ADDR_W+1:0] addr_q;
  logic [31:0]       wdata_q;
  logic              err_q;

  logic              accept;
  logic              req_err;
  logic [31:0]       load_data;
  logic [31:0]       merged;

  assign accept  = req_valid && (state_q == ST_IDLE);
  assign req_err = size_align_err(req_we, req_size, req_addr[1:0]) ||
                   (req_addr[31:ADDR_W+2] != BASE_ADDR[31:ADDR_W+2]);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (req_err)                         state_d = ST_RESP;
          else if (req_we && req_size == SZ_W) state_d = ST_WRITE;
          else                                 state_d = ST_READ;
        end
      end
      ST_WRITE: state_d = ST_RESP;
      ST_READ:  state_d = we_q ? ST_MERGE : ST_LDONE;
      ST_MERGE: state_d = ST_RESP;
      ST_LDONE: state_d = ST_IDLE;
      ST_RESP:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      size_q  <= SZ_B;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        we_q    <= req_we;
        size_q  <= req_size;
        addr_q  <= req_addr[ADDR_W+1:0];
        wdata_q <= req_wdata;
        err_q   <= req_err;
      end
    end
  end

  data_mem_ctrl_align u_align (
    .size      (size_q),
    .addr_lo   (addr_q[1:0]),
    .word      (ram_dout),
    .wdata     (wdata_q),
    .load_data (load_data),
    .merged    (merged)
  );

  // RAM and response outputs are pure state decodes, so an async reset drops ram_we at once.
  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_LDONE) || (state_q == ST_RESP);
  assign rsp_err   = (state_q == ST_RESP) && err_q;
  assign rsp_rdata = (state_q == ST_LDONE) ? load_data : '0;
  assign ram_addr  = addr_q[ADDR_W+1:2];
  assign ram_we    = (state_q == ST_WRITE) || (state_q == ST_MERGE);
  assign ram_din   = (state_q == ST_WRITE) ? wdata_q :
                     (state_q == ST_MERGE) ? merged  : '0;

endmodule
